// File: rtl/tlk2711_tx_sched.sv
// Line scheduler for the TLK2711 TX DMA read path: latches a frame configuration,
// issues one read command per line, tracks completion and raises line/frame interrupts.
module tlk2711_tx_sched #(
  parameter int ADDR_WIDTH = 40,
  parameter int DLEN_WIDTH = 16,
  parameter int CNT_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [DLEN_WIDTH-1:0] i_line_len,
  input  logic [CNT_WIDTH-1:0]  i_line_num,
  input  logic [CNT_WIDTH-1:0]  i_lines_per_irq,
  output logic                  o_cmd_valid,
  input  logic                  i_cmd_ready,
  output logic [ADDR_WIDTH-1:0] o_cmd_addr,
  output logic [DLEN_WIDTH-1:0] o_cmd_len,
  output logic                  o_cmd_last,
  input  logic                  i_dma_done,
  input  logic                  i_dma_err,
  output logic                  o_irq,
  input  logic                  i_irq_clr,
  output logic                  o_busy,
  output logic                  o_err,
  output logic [CNT_WIDTH-1:0]  o_line_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_ERR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DLEN_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  per_q, per_d;
  logic [CNT_WIDTH-1:0]  line_cnt_q, line_cnt_d;
  logic [CNT_WIDTH-1:0]  irq_cnt_q, irq_cnt_d;
  logic [CNT_WIDTH-1:0]  line_inc, irq_inc;
  logic                  stop_q, stop_d;
  logic                  err_d;
  logic                  irq_set;

  assign line_inc = line_cnt_q + CNT_WIDTH'(1);
  assign irq_inc  = irq_cnt_q + CNT_WIDTH'(1);

  // NOTE: every signal is given its hold value first so no path through the case leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    num_d      = num_q;
    per_d      = per_q;
    line_cnt_d = line_cnt_q;
    irq_cnt_d  = irq_cnt_q;
    stop_d     = stop_q;
    err_d      = o_err;
    irq_set    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_line_num != '0 && i_line_len != '0) begin
            addr_d     = i_base_addr;
            len_d      = i_line_len;
            num_d      = i_line_num;
            per_d      = i_lines_per_irq;
            line_cnt_d = '0;
            irq_cnt_d  = '0;
            stop_d     = 1'b0;
            err_d      = 1'b0;
            state_d    = S_CMD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      // The command stays presented until accepted; a stop only takes effect after the line.
      S_CMD: begin
        if (i_stop)      stop_d  = 1'b1;
        if (i_cmd_ready) state_d = S_WAIT;
      end

      S_WAIT: begin
        if (i_dma_err) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (i_dma_done) begin
          line_cnt_d = line_inc;
          addr_d     = addr_q + ADDR_WIDTH'(len_q);
          irq_cnt_d  = irq_inc;
          if (per_q != '0 && irq_inc == per_q) begin
            irq_set   = 1'b1;
            irq_cnt_d = '0;
          end
          if (line_inc == num_q) begin
            irq_set = 1'b1;
            state_d = S_IDLE;
          end else if (stop_q || i_stop) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_CMD;
          end
        end else if (i_stop) begin
          stop_d = 1'b1;
        end
      end

      S_ERR: begin
        if (i_stop) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      num_q       <= '0;
      per_q       <= '0;
      line_cnt_q  <= '0;
      irq_cnt_q   <= '0;
      stop_q      <= 1'b0;
      o_err       <= 1'b0;
      o_irq       <= 1'b0;
      o_cmd_valid <= 1'b0;
      o_cmd_last  <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      num_q       <= num_d;
      per_q       <= per_d;
      line_cnt_q  <= line_cnt_d;
      irq_cnt_q   <= irq_cnt_d;
      stop_q      <= stop_d;
      o_err       <= err_d;
      o_irq       <= irq_set | (o_irq & ~i_irq_clr);
      o_cmd_valid <= (state_d == S_CMD);
      o_cmd_last  <= (state_d == S_CMD) && (line_cnt_d == num_d - CNT_WIDTH'(1));
      o_busy      <= (state_d != S_IDLE);
    end
  end

  assign o_cmd_addr = addr_q;
  assign o_cmd_len  = len_q;
  assign o_line_cnt = line_cnt_q;

endmodule

// File: tb/tb_tlk2711_tx_sched.sv
// Self-checking bench for tlk2711_tx_sched: directed scenarios plus randomized frames
// compared against a line-by-line frame model.
module tb_tlk2711_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0, i_stop = 1'b0;
  logic [39:0] i_base_addr = '0;
  logic [15:0] i_line_len = '0;
  logic [23:0] i_line_num = '0, i_lines_per_irq = '0;
  logic        o_cmd_valid, i_cmd_ready = 1'b0;
  logic [39:0] o_cmd_addr;
  logic [15:0] o_cmd_len;
  logic        o_cmd_last;
  logic        i_dma_done = 1'b0, i_dma_err = 1'b0;
  logic        o_irq, i_irq_clr = 1'b0;
  logic        o_busy, o_err;
  logic [23:0] o_line_cnt;

  int passed = 0;
  int total  = 0;
  bit exp_irq = 1'b0;

  tlk2711_tx_sched dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
    .i_base_addr(i_base_addr), .i_line_len(i_line_len), .i_line_num(i_line_num),
    .i_lines_per_irq(i_lines_per_irq), .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready),
    .o_cmd_addr(o_cmd_addr), .o_cmd_len(o_cmd_len), .o_cmd_last(o_cmd_last),
    .i_dma_done(i_dma_done), .i_dma_err(i_dma_err), .o_irq(o_irq), .i_irq_clr(i_irq_clr),
    .o_busy(o_busy), .o_err(o_err), .o_line_cnt(o_line_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " valid"}, 64'(o_cmd_valid), 64'(0));
    check({tag, " busy"},  64'(o_busy), 64'(0));
  endtask

  task automatic clear_irq();
    i_irq_clr = 1'b1;
    step();
    i_irq_clr = 1'b0;
    exp_irq = 1'b0;
    check("irq cleared", 64'(o_irq), 64'(0));
  endtask

  // Drives a whole frame and checks every command, count and interrupt against the model:
  // line k lives at base + k*len (mod 2^40), is last when k == num-1, and the interrupt
  // fires after line k when (k+1) is a multiple of per (per != 0) or the frame ends.
  task automatic run_frame(input logic [39:0] base, input logic [15:0] len,
                           input logic [23:0] num, input logic [23:0] per,
                           input int stall_lo, input int stall_hi, input int dly_lo,
                           input int stop_line, input int err_line, input bit clr);
    logic [39:0] exp_addr;
    int stalls, dly;
    i_base_addr = base; i_line_len = len; i_line_num = num; i_lines_per_irq = per;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    // Scramble the inputs: the latched configuration must not follow them.
    i_base_addr = ~base; i_line_len = ~len; i_line_num = 24'd1; i_lines_per_irq = 24'd1;
    check("start busy", 64'(o_busy), 64'(1));
    check("start err clear", 64'(o_err), 64'(0));
    check("start line_cnt", 64'(o_line_cnt), 64'(0));
    for (int k = 0; k < int'(num); k++) begin
      exp_addr = base + 40'(k) * 40'(len);
      check("cmd valid", 64'(o_cmd_valid), 64'(1));
      check("cmd addr", 64'(o_cmd_addr), 64'(exp_addr));
      check("cmd len", 64'(o_cmd_len), 64'(len));
      check("cmd last", 64'(o_cmd_last), 64'(k == int'(num) - 1));
      stalls = int'($urandom_range(stall_hi, stall_lo));
      for (int s = 0; s < stalls; s++) begin
        step();
        check("stall valid", 64'(o_cmd_valid), 64'(1));
        check("stall addr", 64'(o_cmd_addr), 64'(exp_addr));
      end
      i_cmd_ready = 1'b1;
      step();
      i_cmd_ready = 1'b0;
      check("post-handshake valid", 64'(o_cmd_valid), 64'(0));
      if (k == stop_line) begin
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        check("stop waits for line", 64'(o_busy), 64'(1));
      end
      dly = int'($urandom_range(3, dly_lo));
      for (int d = 0; d < dly; d++) begin
        if (d == 0 && clr && exp_irq) begin
          i_irq_clr = 1'b1;
          exp_irq = 1'b0;
        end
        step();
        i_irq_clr = 1'b0;
        check("wait no cmd", 64'(o_cmd_valid), 64'(0));
      end
      if (k == err_line) begin
        i_dma_err = 1'b1;
        step();
        i_dma_err = 1'b0;
        check("err flag", 64'(o_err), 64'(1));
        check("err busy", 64'(o_busy), 64'(1));
        check("err line_cnt", 64'(o_line_cnt), 64'(k));
        check("err no cmd", 64'(o_cmd_valid), 64'(0));
        return;
      end
      i_dma_done = 1'b1;
      step();
      i_dma_done = 1'b0;
      if ((per != 0 && ((k + 1) % int'(per)) == 0) || k == int'(num) - 1) exp_irq = 1'b1;
      check("line_cnt", 64'(o_line_cnt), 64'(k + 1));
      check("irq", 64'(o_irq), 64'(exp_irq));
      if (k == int'(num) - 1) begin
        check_idle_outputs("frame end");
        return;
      end
      if (k == stop_line) begin
        check_idle_outputs("stopped");
        step();
        check("stopped stays idle", 64'(o_cmd_valid), 64'(0));
        return;
      end
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst valid", 64'(o_cmd_valid), 64'(0));
    check("rst addr", 64'(o_cmd_addr), 64'(0));
    check("rst len", 64'(o_cmd_len), 64'(0));
    check("rst last", 64'(o_cmd_last), 64'(0));
    check("rst irq", 64'(o_irq), 64'(0));
    check("rst busy", 64'(o_busy), 64'(0));
    check("rst err", 64'(o_err), 64'(0));
    check("rst line_cnt", 64'(o_line_cnt), 64'(0));
    #3 rst_n = 1'b1;
    step();

    // Basic frame: 6 lines of 10752 bytes, interrupt every 3 lines, cleared in between
    run_frame(40'h0, 16'd10752, 24'd6, 24'd3, 0, 2, 1, -1, -1, 1'b1);
    check("basic final line_cnt", 64'(o_line_cnt), 64'(6));
    clear_irq();

    // Backpressure: 20 stalled cycles per command
    run_frame(40'h10_0000, 16'h0400, 24'd2, 24'd0, 20, 20, 0, -1, -1, 1'b0);
    clear_irq();

    // Stop during line 2 wait
    run_frame(40'h0, 16'd10752, 24'd6, 24'd3, 0, 1, 0, 1, -1, 1'b0);
    check("stop no irq", 64'(o_irq), 64'(0));

    // Error on line 4, start ignored in ERR, stop returns to IDLE
    run_frame(40'h2000, 16'h100, 24'd6, 24'd3, 0, 1, 1, -1, 3, 1'b1);
    i_base_addr = 40'h0; i_line_len = 16'h10; i_line_num = 24'd2; i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("err ignores start valid", 64'(o_cmd_valid), 64'(0));
    check("err ignores start busy", 64'(o_busy), 64'(1));
    check("err sticky", 64'(o_err), 64'(1));
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    check_idle_outputs("err stop");
    check("err after stop", 64'(o_err), 64'(1));
    run_frame(40'h0, 16'h40, 24'd1, 24'd0, 0, 1, 0, -1, -1, 1'b1);
    clear_irq();

    // Boundary (a): zero line count and zero line length are rejected
    i_base_addr = 40'h0; i_line_len = 16'h100; i_line_num = 24'd0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("num0 err", 64'(o_err), 64'(1));
    check_idle_outputs("num0");
    step();
    check("num0 no cmd", 64'(o_cmd_valid), 64'(0));
    i_line_len = 16'h0; i_line_num = 24'd3; i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("len0 err", 64'(o_err), 64'(1));
    check_idle_outputs("len0");

    // Boundary (b): per_irq = 0 -> interrupt at frame end only
    run_frame(40'h8000, 16'h200, 24'd4, 24'd0, 0, 2, 0, -1, -1, 1'b0);
    clear_irq();

    // Boundary (c): address wraps modulo 2^40
    run_frame(40'hFF_FFFF_F000, 16'h2000, 24'd2, 24'd0, 0, 1, 0, -1, -1, 1'b0);
    clear_irq();

    // Boundary (d): clear coincident with set keeps the interrupt
    i_base_addr = 40'h40; i_line_len = 16'h20; i_line_num = 24'd1; i_lines_per_irq = 24'd0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("coinc cmd valid", 64'(o_cmd_valid), 64'(1));
    i_cmd_ready = 1'b1;
    step();
    i_cmd_ready = 1'b0;
    i_dma_done = 1'b1; i_irq_clr = 1'b1;
    step();
    i_dma_done = 1'b0; i_irq_clr = 1'b0;
    check("set beats clr", 64'(o_irq), 64'(1));
    exp_irq = 1'b1;

    // Async reset in CMD, between clock edges
    i_base_addr = 40'h1234; i_line_len = 16'h80; i_line_num = 24'd3; i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("pre-reset valid", 64'(o_cmd_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async valid", 64'(o_cmd_valid), 64'(0));
    check("async addr", 64'(o_cmd_addr), 64'(0));
    check("async len", 64'(o_cmd_len), 64'(0));
    check("async irq", 64'(o_irq), 64'(0));
    check("async busy", 64'(o_busy), 64'(0));
    check("async line_cnt", 64'(o_line_cnt), 64'(0));
    #1 rst_n = 1'b1;
    exp_irq = 1'b0;
    step();
    run_frame(40'h4000, 16'h300, 24'd3, 24'd2, 0, 2, 0, -1, -1, 1'b1);

    // Randomized frames against the model
    for (int f = 0; f < 8; f++) begin
      logic [39:0] rb;
      logic [15:0] rl;
      rb = {8'($urandom), 32'($urandom)};
      rl = 16'($urandom_range(16'hFFFF, 1));
      run_frame(rb, rl, 24'($urandom_range(8, 1)), 24'($urandom_range(4, 0)),
                0, 3, 0, -1, -1, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
